// File: rtl/bmul_pkg.sv
// bmul_pkg: shared types and helpers for the bmul_fx_seq multiplier.
//   state_t : FSM state encoding (idle, shift-add, finalise, hold result)
//   clog2   : counter width for W iterations (minimum 1 bit)
package bmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN,
        ST_HOLD
    } state_t;

    function automatic int clog2(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bmul_round_sat.sv
// bmul_round_sat: combinational round-to-nearest (ties toward +inf) and
// saturation of a (2IW).(2FW) product down to IW.FW.
//   p     in  2W : full-precision product
//   sgn   in  1  : 1 = two's complement, 0 = unsigned
//   res_q out W  : rounded, saturated result
//   ovf   out 1  : res_q was clamped
module bmul_round_sat #(
    parameter int IW = 8,
    parameter int FW = 8
) (
    input  logic [2*(IW+FW)-1:0] p,
    input  logic                 sgn,
    output logic [IW+FW-1:0]     res_q,
    output logic                 ovf
);

    localparam int W  = IW + FW;
    localparam int RW = 2 * W + 1;
    localparam logic [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FW - 1);

    logic [RW-1:0] ext;
    logic [RW-1:0] sum;
    logic [RW-1:0] r;

    always_comb begin
        // One extra bit so the rounding carry can never wrap.
        ext = {sgn & p[2*W-1], p};
        sum = ext + HALF;
        // if/else rather than ?: so the signed shift is not forced unsigned
        // by the other branch of the expression.
        if (sgn) r = $signed(sum) >>> FW;
        else     r = sum >> FW;

        res_q = r[W-1:0];
        ovf   = 1'b0;
        if (sgn) begin
            // In range when every bit from W-1 upward is a copy of the sign.
            if (!((&r[RW-1:W-1]) || !(|r[RW-1:W-1]))) begin
                ovf   = 1'b1;
                res_q = r[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end else if (|r[RW-1:W]) begin
            ovf   = 1'b1;
            res_q = {W{1'b1}};
        end
    end

endmodule

// File: rtl/bmul_fx_seq.sv
// bmul_fx_seq: sequential shift-add IW.FW fixed-point multiplier.
// Magnitudes are multiplied unsigned over W cycles, the sign is applied in
// FIN, and the product is rounded/saturated back to IW.FW.
//   clk, rst          : clock, synchronous active-low reset
//   in_vld/in_rdy     : operand handshake (in_rdy = idle)
//   a, b (W), sgn     : operands and signed-mode flag
//   res_full (2W)     : exact product
//   res_q (W), ovf    : rounded/saturated product, saturation flag
//   res_vld/res_rdy   : result handshake (res_vld = holding a result)
module bmul_fx_seq
    import bmul_pkg::*;
#(
    parameter int IW = 8,
    parameter int FW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [IW+FW-1:0]       a,
    input  logic [IW+FW-1:0]       b,
    input  logic                   sgn,
    output logic [2*(IW+FW)-1:0]   res_full,
    output logic [IW+FW-1:0]       res_q,
    output logic                   ovf,
    output logic                   res_vld,
    input  logic                   res_rdy
);

    localparam int W  = IW + FW;
    localparam int CW = clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic [2*W-1:0]   full_q, full_d;
    logic [W-1:0]     rnd_q, rnd_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     a_mag, b_mag;
    logic [2*W-1:0]   p_fin;
    logic [W-1:0]     rs_res;
    logic             rs_ovf;

    bmul_round_sat #(.IW(IW), .FW(FW)) u_round_sat (
        .p     (p_fin),
        .sgn   (sgn_q),
        .res_q (rs_res),
        .ovf   (rs_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sgn_d    = sgn_q;
        neg_d    = neg_q;
        full_d   = full_q;
        rnd_d    = rnd_q;
        ovf_d    = ovf_q;

        // -(2^(W-1)) wraps to itself, which is the correct unsigned magnitude.
        a_mag = (sgn & a[W-1]) ? -a : a;
        b_mag = (sgn & b[W-1]) ? -b : b;
        p_fin = neg_q ? -acc_q : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_vld) begin
                    state_d  = ST_CALC;
                    sgn_d    = sgn;
                    neg_d    = sgn & (a[W-1] ^ b[W-1]);
                    mcand_d  = {{W{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                full_d  = p_fin;
                rnd_d   = rs_res;
                ovf_d   = rs_ovf;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            full_q   <= '0;
            rnd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            full_q   <= full_d;
            rnd_q    <= rnd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_rdy   = (state_q == ST_IDLE);
    assign res_vld  = (state_q == ST_HOLD);
    assign res_full = full_q;
    assign res_q    = rnd_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_bmul_fx_seq.sv
// tb_bmul_fx_seq: directed scoreboard bench for bmul_fx_seq (IW=FW=8).
module tb_bmul_fx_seq;

    localparam int IW = 8;
    localparam int FW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sgn = 1'b0;
    logic [31:0] res_full;
    logic [15:0] res_q;
    logic        ovf;
    logic        res_vld;
    logic        res_rdy = 1'b1;

    logic [31:0] rs_p = '0;
    logic        rs_sgn = 1'b0;
    logic [15:0] rs_res;
    logic        rs_ovf;

    bmul_fx_seq #(.IW(IW), .FW(FW)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .a(a), .b(b), .sgn(sgn), .res_full(res_full), .res_q(res_q),
        .ovf(ovf), .res_vld(res_vld), .res_rdy(res_rdy)
    );

    bmul_round_sat #(.IW(IW), .FW(FW)) u_rs (
        .p(rs_p), .sgn(rs_sgn), .res_q(rs_res), .ovf(rs_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tot = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] full;
        logic [15:0] q;
        logic        ovf;
        int          acc;
    } exp_t;
    exp_t sb[$];
    logic prev_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every rising edge of res_vld.
    always @(negedge clk) begin
        exp_t e;
        if (res_vld === 1'b1 && prev_vld !== 1'b1) begin
            if (sb.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL unexpected_res_vld: got res_vld=1 expected no result at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("res_full", 64'(res_full), 64'(e.full));
                chk("res_q",    64'(res_q),    64'(e.q));
                chk("ovf",      64'(ovf),      64'(e.ovf));
                chk("latency",  64'(cyc - e.acc), 64'd17);
            end
        end
        prev_vld <= res_vld;
    end

    // Entered and left at a negedge.
    task automatic op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                      input logic [31:0] ef, input logic [15:0] eq, input logic eo,
                      input bit push);
        int n;
        exp_t e;
        n = 0;
        while (in_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_rdy !== 1'b1) begin
            tot++;
            bad++;
            $display("FAIL in_rdy_timeout: got in_rdy=%b expected 1", in_rdy);
            return;
        end
        a = ta; b = tb_v; sgn = ts; in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        if (push) begin
            e.full = ef; e.q = eq; e.ovf = eo; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_rdy !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tot++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_res_full"}, 64'(res_full), 64'd0);
        chk({tag, "_res_q"},    64'(res_q),    64'd0);
        chk({tag, "_ovf"},      64'(ovf),      64'd0);
        chk({tag, "_res_vld"},  64'(res_vld),  64'd0);
        chk({tag, "_in_rdy"},   64'(in_rdy),   64'd1);
    endtask

    initial begin
        int n;
        // Standalone rounding/saturation unit: negative ties and underflow.
        rs_sgn = 1'b1; rs_p = 32'hFFFF_FF80; #1;
        chk("rs_tie_neg_q", 64'(rs_res), 64'h0000);
        chk("rs_tie_neg_ovf", 64'(rs_ovf), 64'd0);
        rs_p = 32'hFFFF_FF7F; #1;
        chk("rs_below_tie_q", 64'(rs_res), 64'hFFFF);
        rs_p = 32'h8000_0000; #1;
        chk("rs_neg_sat_q", 64'(rs_res), 64'h8000);
        chk("rs_neg_sat_ovf", 64'(rs_ovf), 64'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;

        op(16'h0180, 16'h0240, 1'b0, 32'h0003_6000, 16'h0360, 1'b0, 1'b1);
        op(16'hFE80, 16'h0240, 1'b1, 32'hFFFC_A000, 16'hFCA0, 1'b0, 1'b1);
        op(16'h0001, 16'h0080, 1'b0, 32'h0000_0080, 16'h0001, 1'b0, 1'b1);
        op(16'h0001, 16'h007F, 1'b0, 32'h0000_007F, 16'h0000, 1'b0, 1'b1);
        op(16'h2000, 16'h2000, 1'b0, 32'h0400_0000, 16'hFFFF, 1'b1, 1'b1);
        op(16'h2000, 16'h2000, 1'b1, 32'h0400_0000, 16'h7FFF, 1'b1, 1'b1);
        op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Backpressure: result must hold and new operands must be ignored.
        res_rdy = 1'b0;
        op(16'h0300, 16'h0200, 1'b0, 32'h0006_0000, 16'h0600, 1'b0, 1'b1);
        n = 0;
        while (res_vld !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_vld_seen", 64'(res_vld), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_vld = i[0];
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            chk("bp_res_full", 64'(res_full), 64'h0006_0000);
            chk("bp_res_q",    64'(res_q),    64'h0600);
            chk("bp_res_vld",  64'(res_vld),  64'd1);
            chk("bp_in_rdy",   64'(in_rdy),   64'd0);
        end
        in_vld = 1'b0;
        res_rdy = 1'b1;
        @(negedge clk);
        chk("hs_res_vld", 64'(res_vld), 64'd0);
        chk("hs_in_rdy",  64'(in_rdy),  64'd1);
        chk("hs_res_full_kept", 64'(res_full), 64'h0006_0000);
        op(16'h0400, 16'h0400, 1'b1, 32'h0010_0000, 16'h1000, 1'b0, 1'b1);
        drain();

        // Reset during CALC aborts the operation.
        op(16'h0180, 16'h0240, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("midrst");
        rst = 1'b1;
        repeat (25) @(negedge clk);
        op(16'h0180, 16'h0240, 1'b0, 32'h0003_6000, 16'h0360, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
